// File: rtl/rv32e_lsu_if.sv
// rtl/rv32e_lsu_if.sv - LSU data-bus interface (req/gnt/rvalid)
// Ports (master = LSU, slave = memory):
//   mem_req, mem_we, mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  master -> slave
//   mem_gnt, mem_rvalid, mem_rdata[31:0]                              slave -> master
interface rv32e_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv32e_lsu.sv
// rtl/rv32e_lsu.sv - RV32E load/store unit, one access per lsu_valid
// Ports:
//   clk, rst (sync, active-high)
//   lsu_valid, lsu_we, funct3[2:0], addr[31:0], wdata[31:0], rd_in[4:0]  access request
//   stall, done, rdata[31:0], rd_out[4:0], reg_write, exc, exc_cause[1:0] core result
//   bus (rv32e_lsu_if.master)                                           data bus
// Optional: RV32E_LSU_TIMEOUT_EN enables the bus-response watchdog (TIMEOUT_CYCLES).
module rv32e_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [4:0]  rd_out,
  output logic        reg_write,
  output logic        exc,
  output logic [1:0]  exc_cause,
  rv32e_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        f3_illegal;
  logic        misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        rsp_ok;

  // Request decode, evaluated on the acceptance cycle from the live inputs.
  always_comb begin
    f3_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && lsu_we);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00:   begin st_wstrb = 4'b0001 << addr[1:0];               st_wdata = {4{wdata[7:0]}};  end
      2'b01:   begin st_wstrb = addr[1] ? 4'b1100 : 4'b0011;        st_wdata = {2{wdata[15:0]}}; end
      default: begin st_wstrb = 4'b1111;                            st_wdata = wdata;            end
    endcase
  end

  // Load extraction uses the latched size and byte offset.
  always_comb begin
    ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // rvalid only counts in REQ when it arrives together with the grant.
  assign rsp_ok = ((state == REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                  ((state == WAIT) && bus.mem_rvalid);

  assign stall = ((state == IDLE) && lsu_valid) || (state == REQ) || (state == WAIT);

`ifdef RV32E_LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  // Counter is 0 in the first REQ cycle, so the watchdog fires on the
  // TIMEOUT_CYCLES-th cycle spent waiting and DONE lands that many cycles after REQ entry.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // The limit only matters when the watchdog is built in.
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      done          <= 1'b0;
      rdata         <= 32'h0;
      rd_out        <= 5'd0;
      reg_write     <= 1'b0;
      exc           <= 1'b0;
      exc_cause     <= 2'b00;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wstrb <= 4'b0000;
      bus.mem_wdata <= 32'h0;
`ifdef RV32E_LSU_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      done      <= 1'b0;
      reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            we_q   <= lsu_we;
            f3_q   <= funct3;
            off_q  <= addr[1:0];
            rd_out <= rd_in;
            rdata  <= 32'h0;
            if (f3_illegal) begin
              state     <= DONE;
              done      <= 1'b1;
              exc       <= 1'b1;
              exc_cause <= 2'b10;
            end else if (misaligned) begin
              state     <= DONE;
              done      <= 1'b1;
              exc       <= 1'b1;
              exc_cause <= 2'b01;
            end else begin
              state         <= REQ;
              exc           <= 1'b0;
              exc_cause     <= 2'b00;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= lsu_we;
              bus.mem_addr  <= {addr[31:2], 2'b00};
              bus.mem_wstrb <= lsu_we ? st_wstrb : 4'b0000;
              bus.mem_wdata <= st_wdata;
`ifdef RV32E_LSU_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end
          end
        end
        REQ, WAIT: begin
`ifdef RV32E_LSU_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          if (rsp_ok) begin
            state       <= DONE;
            done        <= 1'b1;
            bus.mem_req <= 1'b0;
            rdata       <= we_q ? 32'h0 : ld_data;
            reg_write   <= ~we_q;
          end
`ifdef RV32E_LSU_TIMEOUT_EN
          else if (tmo_hit) begin
            state       <= DONE;
            done        <= 1'b1;
            bus.mem_req <= 1'b0;
            exc         <= 1'b1;
            exc_cause   <= 2'b11;
            rdata       <= 32'h0;
          end
`endif
          else if ((state == REQ) && bus.mem_gnt) begin
            state       <= WAIT;
            bus.mem_req <= 1'b0;
          end
        end
        DONE: begin
          state     <= IDLE;
          exc       <= 1'b0;
          exc_cause <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32e_lsu.sv
// tb/tb_rv32e_lsu.sv - randomized self-checking bench for rv32e_lsu
module tb_rv32e_lsu;

`ifdef RV32E_LSU_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [4:0]  rd_out;
  logic        reg_write;
  logic        exc;
  logic [1:0]  exc_cause;

  int checks   = 0;
  int failures = 0;

  rv32e_lsu_if bus ();

  rv32e_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu_valid (lsu_valid),
    .lsu_we    (lsu_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rd_in     (rd_in),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .rd_out    (rd_out),
    .reg_write (reg_write),
    .exc       (exc),
    .exc_cause (exc_cause),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] m_cause(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b10;
    if ((a % m_size(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_wstrb(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!we) return 4'b0000;
    n = m_size(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  // Each byte lane carries the store byte that lines up with it modulo the access size.
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    longint v;
    int n;
    n = m_size(f3);
    v = longint'(w) >> (8 * (a % 4));
    v = v & ((longint'(1) << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Entered #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
  task automatic run_txn(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int gd, input int rv,
                         input logic [31:0] word);
    logic [1:0] cause;
    int done_t;
    cause  = m_cause(we, f3, a);
    done_t = (cause != 2'b00) ? 1 : 2 + gd + rv;
    lsu_valid = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = d; rd_in = rd;
    #1 chk({tag, ".stall_t0"}, 32'(stall), 32'd1);
    for (int t = 1; t <= done_t; t++) begin
      @(posedge clk); #1;
      if (t < done_t) begin
        // Junk on the request side while busy must be ignored.
        lsu_valid = 1'($urandom % 2); lsu_we = 1'($urandom % 2); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom; rd_in = 5'($urandom);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(t <= 1 + gd));
        if (t <= 1 + gd) begin
          chk({tag, ".mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
          chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
          chk({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(m_wstrb(we, f3, a)));
          if (we) chk({tag, ".mem_wdata"}, bus.mem_wdata, m_wdata(f3, d));
        end
        bus.mem_gnt    = (t == 1 + gd);
        bus.mem_rvalid = (t == 1 + gd + rv) || ((t < 1 + gd) && (($urandom % 2) == 1));
        bus.mem_rdata  = (t == 1 + gd + rv) ? word : $urandom;
      end else begin
        lsu_valid = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".exc"}, 32'(exc), 32'(cause != 2'b00));
        chk({tag, ".exc_cause"}, 32'(exc_cause), 32'(cause));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(!we && cause == 2'b00));
        chk({tag, ".rdata"}, rdata, (!we && cause == 2'b00) ? m_rdata(f3, a, word) : 32'h0);
        chk({tag, ".rd_out"}, 32'(rd_out), 32'(rd));
        chk({tag, ".mem_req_done"}, 32'(bus.mem_req), 32'd0);
      end
    end
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    chk({tag, ".reg_write_pulse"}, 32'(reg_write), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; rd_in = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("sw",   1'b1, 3'b010, 32'h0000_0104, 32'hDEADBEEF, 5'd3,  0, 1, 32'h0);
    run_txn("lb",   1'b0, 3'b000, 32'h0000_0203, 32'h0,        5'd7,  0, 0, 32'h80FF_1234);
    run_txn("lbu",  1'b0, 3'b100, 32'h0000_0203, 32'h0,        5'd8,  1, 1, 32'h80FF_1234);
    run_txn("lh",   1'b0, 3'b001, 32'h0000_0202, 32'h0,        5'd9,  0, 2, 32'h80FF_1234);
    run_txn("lx0",  1'b0, 3'b010, 32'h0000_0040, 32'h0,        5'd0,  2, 0, 32'h1357_9BDF);
    run_txn("sb",   1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd1, 0, 0, 32'h0);
    run_txn("sh",   1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 5'd2, 1, 0, 32'h0);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0,      5'd4,  0, 0, 32'h0);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0000_0000, 32'h0,      5'd5,  0, 0, 32'h0);
    run_txn("sbu",  1'b1, 3'b100, 32'h0000_0000, 32'h0,        5'd6,  0, 0, 32'h0);

    // Reset while waiting for the response; a late rvalid must not complete anything.
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040; rd_in = 5'd11;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      if (t <= 4) begin
        chk("rst_mid.mem_req", 32'(bus.mem_req), 32'd1);
        chk("rst_mid.mem_addr", bus.mem_addr, 32'h0000_0040);
      end
      bus.mem_gnt = (t == 4);
      bus.mem_rvalid = (t == 6);
      bus.mem_rdata = $urandom;
      if (t == 5) begin
        chk("rst_mid.wait_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid.wait_stall", 32'(stall), 32'd1);
        rst = 1'b1;
      end
      if (t == 6) begin
        rst = 1'b0;
        chk("rst_mid.stall", 32'(stall), 32'd0);
        chk("rst_mid.done", 32'(done), 32'd0);
        chk("rst_mid.mem_req0", 32'(bus.mem_req), 32'd0);
        chk("rst_mid.mem_addr0", bus.mem_addr, 32'h0);
        chk("rst_mid.rd_out", 32'(rd_out), 32'd0);
        chk("rst_mid.exc", 32'(exc), 32'd0);
      end
      if (t >= 7) begin
        chk("rst_mid.stray_done", 32'(done), 32'd0);
        chk("rst_mid.stray_rw", 32'(reg_write), 32'd0);
      end
    end

`ifdef RV32E_LSU_TIMEOUT_EN
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; rd_in = 5'd12;
    for (int t = 1; t <= TMO + 1; t++) begin
      @(posedge clk); #1;
      lsu_valid = 1'b0;
      bus.mem_gnt = (t == 1);
      bus.mem_rvalid = 1'b0;
      if (t <= TMO) chk("tmo.done_early", 32'(done), 32'd0);
      else begin
        bus.mem_gnt = 1'b0;
        chk("tmo.done", 32'(done), 32'd1);
        chk("tmo.exc", 32'(exc), 32'd1);
        chk("tmo.exc_cause", 32'(exc_cause), 32'd3);
        chk("tmo.reg_write", 32'(reg_write), 32'd0);
        chk("tmo.mem_req", 32'(bus.mem_req), 32'd0);
      end
    end
    @(posedge clk); #1;
`else
    run_txn("long_wait", 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd13, 0, 30, 32'hCAFE_F00D);
`endif

    for (int i = 0; i < 80; i++) begin
      run_txn($sformatf("rnd%0d", i), 1'($urandom % 2), 3'($urandom), $urandom, $urandom,
              5'($urandom), int'($urandom % 5), int'($urandom % 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32e_lsu.md
Name: rv32e_lsu

Overview:
Load/store unit sitting directly downstream of the ALU in the RV32E core. It takes the ALU-computed effective address plus the store data/funct3 from decode, and performs one memory access over a simple req/gnt/rvalid data bus. It returns aligned, sign/zero-extended load data for register write-back. It holds the core stalled (PC and RF write frozen) until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, bus-response watchdog limit in cycles (used only with RV32E_LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
lsu_valid  in  1  start access this cycle (load or store opcode decoded)
lsu_we  in  1  1 = store, 0 = load
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective byte address (ALU result)
wdata  in  32  store data (rs2_data)
rd_in  in  5  destination register of load
stall  out  1  core must hold PC/RF write
done  out  1  one-cycle pulse: access finished
rdata  out  32  extended load data, valid while done=1
rd_out  out  5  latched rd, valid while done=1
reg_write  out  1  done & load & no exception
exc  out  1  exception flag, valid while done=1
exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  bus write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wstrb  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  32  read data word

Behaviour:
- Reset values: state IDLE; stall, done, reg_write, exc, mem_req, mem_we = 0; exc_cause, mem_wstrb = 0; rdata, rd_out, mem_addr, mem_wdata = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on lsu_valid, latch lsu_we, funct3, addr, wdata, rd_in.
  - If funct3 illegal (011/110/111, or 100/101 with lsu_we=1) -> DONE, exc_cause=10.
  - Else if misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> DONE, exc_cause=01.
  - Else -> REQ.
  - In both exception cases no bus request is issued.
- REQ: mem_req=1 with mem_* stable.
  - mem_gnt & mem_rvalid -> DONE.
  - mem_gnt alone -> WAIT.
  - mem_rvalid without mem_gnt is ignored.
- WAIT: mem_req=0; mem_rvalid -> DONE. Capture mem_rdata on the transition.
- DONE: done=1 for exactly one cycle, then IDLE. lsu_valid is accepted again only in IDLE.
- stall = (state==IDLE & lsu_valid) | state==REQ | state==WAIT. stall is 0 in DONE, so the core advances on the done cycle.
- Minimum latency: lsu_valid cycle 0, mem_req cycle 1 (gnt+rvalid same cycle), done cycle 2. Zero-wait gnt followed by rvalid one cycle later gives done in cycle 3.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
  - For loads, mem_wstrb = 0000.
- Load extract: select the byte/half by addr[1:0]/addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through. On a store or exception, rdata = 0.
- reg_write = 1 only in DONE for a load with exc=0. A load to rd_out=0 still pulses reg_write (the RF ignores x0).
- lsu_valid while busy is ignored; stall guarantees the core re-presents nothing new.
- Reset mid-access: rst in any state returns to IDLE next edge with outputs at reset values. A late mem_rvalid arriving in IDLE is ignored.

Optional Feature:
RV32E_LSU_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES without mem_rvalid, go to DONE with exc=1, exc_cause=11, mem_req deasserted, and no register write.
- Undefined: no counter; the LSU waits indefinitely and exc_cause=11 is never produced.

Test Plan:
- SW to addr 0x0000_0104, wdata 0xDEADBEEF, gnt same cycle as req, rvalid next cycle -> mem_addr 0x104, wstrb 1111, mem_wdata 0xDEADBEEF, done at cycle 3, reg_write=0, stall high cycles 0-2.
- LB addr 0x0000_0203, mem_rdata 0x80FF_1234 -> rdata 0xFFFF_FF80; LBU same -> 0x0000_0080; LH addr 0x202 -> 0xFFFF_80FF; reg_write=1, rd_out=rd_in.
- SB addr 0x0000_0011, wdata 0x0000_00A5 -> wstrb 0010, mem_wdata 0xA5A5_A5A5; SH addr 0x12 -> wstrb 1100.
- LW addr 0x0000_0006 -> no mem_req ever, done at cycle 1, exc=1, exc_cause=01, reg_write=0. funct3=011 -> exc_cause=10.
- Delay gnt 3 cycles with mem_req held stable; assert rst while in WAIT -> IDLE next edge, all outputs zero, subsequent stray mem_rvalid produces no done.
- With RV32E_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert rvalid -> done with exc_cause=11 at 8 cycles after REQ entry.
